key_cmd_unit: RTL
=================

Name: key_cmd_unit

Overview:
- Sits directly upstream of the player motion block.
- Takes the raw 8-bit keyboard keycode from the USB/NIOS interface, debounces it in the system clock domain, and edge-detects presses.
- Presents a frame-synchronous command set: held movement levels, one-frame action pulses, and a filtered keycode.
- All outputs change only just after a frame_clk rising edge, so the motion block (clocked on frame_clk) always samples stable values.

Parameters:
- DEBOUNCE_CYCLES, 50000: Clk cycles the keycode must be stable before acceptance; 1 ms at 50 MHz; legal range 1..65535.
- REPEAT_FRAMES, 8: frames between auto-repeat fire pulses; only used with the optional feature; legal range 1..255.

Ports:
- Clk  in  1: system clock, 50 MHz.
- Reset  in  1: synchronous, active-high.
- frame_clk  in  1: vertical-sync frame clock, treated as asynchronous data.
- keycode  in  8: raw keycode; 0 = no key.
- cmd_keycode  out  8: debounced keycode, updated on frame tick.
- move_left  out  1: level; cmd key = 4 (A).
- move_right  out  1: level; cmd key = 7 (D).
- jump_pulse  out  1: one frame period high per fresh press of 26 (W).
- crouch_pulse  out  1: one frame period high per fresh press of 22 (S).
- fire_pulse  out  1: one frame period high per fresh press of 44 (space).
- frame_cnt  out  16: count of frame ticks since reset.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Debounce candidate, stable key, count, pending flags and sync flops all 0.
  - Reset asserted mid-operation discards any in-progress debounce and pending presses.
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser (s1, s2) plus a third flop s3.
  - tick = s2 & ~s3: a one-Clk pulse 3 Clk cycles after the frame_clk rising edge.
  - frame_clk held high or low produces no further ticks.
- Debounce FSM, states IDLE / COUNT / STABLE:
  - Any cycle where keycode != candidate: candidate <= keycode, count <= 0, state COUNT. This applies from every state.
  - In COUNT with keycode == candidate: count increments.
  - When count == DEBOUNCE_CYCLES-1: stable <= candidate, state STABLE.
  - Acceptance occurs DEBOUNCE_CYCLES+1 Clk cycles after keycode settles.
  - STABLE holds until keycode differs again.
  - IDLE is the post-reset state with candidate 0.
  - count saturates and never wraps.
- Press edge:
  - Asserted for one Clk when stable changes to value K from any value != K.
  - An edge on 26, 22 or 44 sets the matching pending flag (jump_pend, crouch_pend or fire_pend).
  - Re-accepting the same key after release (going through 0 or another code) is a fresh press.
- On tick:
  - cmd_keycode <= stable.
  - move_left <= (stable == 4); move_right <= (stable == 7).
  - Each X_pulse <= X_pend | X_edge_this_cycle.
  - All pending flags clear, except that an edge coinciding with tick is both output and not re-pended.
  - frame_cnt increments, wrapping 0xFFFF -> 0.
- Pulse outputs:
  - Held from one tick to the next, i.e. exactly one frame period, then cleared unless newly pending.
  - Multiple presses within one frame collapse to one pulse.
  - A press and release both inside one frame still produce one pulse.
- Holding a key yields exactly one pulse; move levels follow stable for as long as the key is held.
- Exclusivity:
  - Only one keycode exists, so at most one of move_left/move_right is high.
  - Pulses may coexist with each other only via pending flags from different presses in the same frame.
- No output changes between ticks.

Optional Feature:
- Macro: KEYCMD_AUTOREPEAT_EN.
- Defined:
  - While stable == 44, an 8-bit repeat counter increments on each tick after the initial pulse.
  - When it reaches REPEAT_FRAMES, fire_pulse is asserted for that frame and the counter resets to 0.
  - The counter clears whenever stable != 44 and on Reset.
- Undefined: no counter is present; a held fire key produces only the single press pulse.

Test Plan:
- Reset, then keycode=26 steady, DEBOUNCE_CYCLES=4, frame_clk period 100 Clk -> jump_pulse=1 from the first tick after acceptance, for exactly one frame; cmd_keycode=26; move_* = 0.
- keycode toggles 7/0 every 2 Clk for 50 Clk, then stays 7, DEBOUNCE_CYCLES=4 -> stable never leaves 0 during toggling; move_right=1 only at the first tick ≥5 Clk after settling.
- keycode=4 held for 5 frames -> move_left=1 for all 5 frames; no pulse outputs; cmd_keycode=4 throughout; frame_cnt advances by 5.
- Within one frame: press 22, release, press 22 again (each held > debounce) -> crouch_pulse high for exactly one frame, not two.
- Reset asserted for 1 Clk while count is mid-debounce and jump_pend=1 -> next tick yields jump_pulse=0, cmd_keycode=0, frame_cnt=1.
- With KEYCMD_AUTOREPEAT_EN and REPEAT_FRAMES=3, keycode=44 held 10 frames -> fire_pulse high in frames 1, 4, 7, 10 relative to acceptance; without the macro, only frame 1.

Source files
------------

// File: rtl/key_cmd_unit.sv
// key_cmd_unit: debounces the raw keyboard keycode in the Clk domain,
// edge-detects presses and presents a frame-synchronous command set
// (movement levels, one-frame action pulses, filtered keycode, frame count).
// All outputs update only on the internal frame tick derived from frame_clk.
// Optional build macro KEYCMD_AUTOREPEAT_EN: a held fire key (44) re-fires
// every REPEAT_FRAMES frames after the initial press pulse.
module key_cmd_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_FRAMES   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  output logic [7:0]  cmd_keycode,
  output logic        move_left,
  output logic        move_right,
  output logic        jump_pulse,
  output logic        crouch_pulse,
  output logic        fire_pulse,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0]  KEY_A     = 8'd4;
  localparam logic [7:0]  KEY_D     = 8'd7;
  localparam logic [7:0]  KEY_S     = 8'd22;
  localparam logic [7:0]  KEY_W     = 8'd26;
  localparam logic [7:0]  KEY_SPACE = 8'd44;
  localparam logic [15:0] CNT_LAST  = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end
  if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
    $error("REPEAT_FRAMES out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    STABLE
  } dbnc_state_e;

  dbnc_state_e state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  stable_q, stable_d;
  logic [7:0]  stable_prev_q;

  logic s1_q, s2_q, s3_q;
  logic tick;

  logic press_edge;
  logic jump_edge, crouch_edge, fire_edge;
  logic jump_pend_q, crouch_pend_q, fire_pend_q;
  logic fire_rpt;

  // frame_clk synchroniser plus delay flop for rising-edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  // Debounce state register and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  // Debounce next-state: any keycode change restarts counting from every state
  always_comb begin
    state_d = state_q;
    if (keycode != cand_q) begin
      state_d = COUNT;
    end else begin
      case (state_q)
        COUNT:   if (cnt_q == CNT_LAST) state_d = STABLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Debounce datapath: capture candidate, count stable cycles, accept
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (keycode != cand_q) begin
      cand_d = keycode;
      cnt_d  = '0;
    end else if (state_q == COUNT) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = cand_q;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // A press edge is seen the cycle after stable takes a new value, so the
  // tick that consumes it already reports the new key on cmd_keycode.
  assign press_edge  = (stable_q != stable_prev_q);
  assign jump_edge   = press_edge & (stable_q == KEY_W);
  assign crouch_edge = press_edge & (stable_q == KEY_S);
  assign fire_edge   = press_edge & (stable_q == KEY_SPACE);

  // Pending presses accumulate between ticks; an edge on the tick goes
  // straight to the output and is not re-pended
  always_ff @(posedge Clk) begin
    if (Reset || tick) begin
      jump_pend_q   <= 1'b0;
      crouch_pend_q <= 1'b0;
      fire_pend_q   <= 1'b0;
    end else begin
      jump_pend_q   <= jump_pend_q   | jump_edge;
      crouch_pend_q <= crouch_pend_q | crouch_edge;
      fire_pend_q   <= fire_pend_q   | fire_edge;
    end
  end

`ifdef KEYCMD_AUTOREPEAT_EN
  localparam logic [7:0] RPT_N = 8'(REPEAT_FRAMES);

  logic [7:0] rpt_q;

  // Repeat counter: counts ticks after the initial fire pulse while 44 is held
  always_ff @(posedge Clk) begin
    if (Reset || (stable_q != KEY_SPACE)) begin
      rpt_q <= '0;
    end else if (tick) begin
      if (fire_pend_q || fire_edge || (rpt_q + 8'd1 == RPT_N)) begin
        rpt_q <= '0;
      end else begin
        rpt_q <= rpt_q + 8'd1;
      end
    end
  end

  assign fire_rpt = tick & (stable_q == KEY_SPACE) & ~(fire_pend_q | fire_edge)
                    & (rpt_q + 8'd1 == RPT_N);
`else
  assign fire_rpt = 1'b0;
`endif

  // Frame-synchronous outputs, changed only on tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cmd_keycode  <= '0;
      move_left    <= 1'b0;
      move_right   <= 1'b0;
      jump_pulse   <= 1'b0;
      crouch_pulse <= 1'b0;
      fire_pulse   <= 1'b0;
      frame_cnt    <= '0;
    end else if (tick) begin
      cmd_keycode  <= stable_q;
      move_left    <= (stable_q == KEY_A);
      move_right   <= (stable_q == KEY_D);
      jump_pulse   <= jump_pend_q | jump_edge;
      crouch_pulse <= crouch_pend_q | crouch_edge;
      fire_pulse   <= fire_pend_q | fire_edge | fire_rpt;
      frame_cnt    <= frame_cnt + 16'd1;
    end
  end

endmodule
